qar_irq_ctrl: RTL and testbench
===============================

// Module: qar_irq_ctrl
// PURPOSE
//  External interrupt controller for qar_core. Synchronises NUM_SRC async sources,
//  latches pending, masks, picks one winner, drives the core's irq_external line.
//  Claim/complete handshake through MMIO slave regs on the data-bus (valid/ready).
//  Consumes irq_external_ack to count taken interrupts (debug counter).
// PARAMETERS
//  NUM_SRC    8   number of interrupt sources, 1..31; source ids are 1..NUM_SRC
//  SYNC_STAGES 2  synchroniser depth per source, >=2
// PORTS
//  clk          in   1        system clock
//  rst          in   1        async active-high reset
//  irq_src      in   NUM_SRC  raw async interrupt sources, active-high
//  bus_valid    in   1        MMIO request (already decoded to this block)
//  bus_we       in   1        1=write 0=read
//  bus_addr     in   5        byte offset; bits [4:2] select reg, [1:0] ignored
//  bus_wdata    in   32       write data
//  bus_ready    out  1        response strobe, 1 cycle
//  bus_rdata    out  32       read data, valid while bus_ready=1
//  irq_external out  1        to qar_core.irq_external
//  irq_ack      in   1        from qar_core.irq_external_ack
// BEHAVIOUR
//  Reset: all regs 0; bus_ready=0, bus_rdata=0, irq_external=0, in_service=0,
//   sync flops 0, FSM=IDLE. Reset mid-transaction drops bus_ready; request lost.
//  Sync: SYNC_STAGES flops per source -> s[i]; prev flop for edge detect.
//  Set condition: EDGE[i]=1 -> s rising edge; EDGE[i]=0 -> s level high.
//  Regs (offset): 0x00 PENDING  R, W1C (W1C affects edge sources only)
//   0x04 ENABLE R/W  0x08 EDGE R/W  0x0C CLAIM R  0x10 COMPLETE W
//   0x14 ACKCNT R, W any clears; 32-bit count of irq_ack rising edges, wraps
//   Bits >= NUM_SRC read 0, writes ignored. Unmapped offsets: read 0, write no-op.
//  Pending: level src pending = s[i] (no latch); edge src latched until claimed/W1C.
//   Set and clear same cycle -> set wins.
//  Winner: among PENDING&ENABLE, lowest index wins (fixed priority).
//  irq_external = |(PENDING&ENABLE) & ~in_service; registered (1 cycle after cond).
//  CLAIM read: returns winner id (index+1), 0 if none; if id!=0: clears edge pending
//   bit, sets in_service, latches svc_id. Claim while in_service returns 0, no change.
//  COMPLETE write: wdata[4:0]==svc_id clears in_service; mismatch ignored.
//  Bus FSM: IDLE -(bus_valid)-> RESP (capture we/addr/wdata; side effects applied at
//   capture edge) -> IDLE. bus_ready=1 exactly in RESP; latency 1, one req per 2
//   cycles min. bus_valid in RESP is ignored; requester holds valid until ready.
//  ACKCNT: irq_ack edge and clear-write same cycle -> clear wins, count=0.
// CONFIGURATION
//  QAR_IRQ_ROUND_ROBIN_EN defined: winner = first PENDING&ENABLE at or after rr_ptr
//   (wrapping at NUM_SRC); successful claim sets rr_ptr = claimed index+1 mod NUM_SRC;
//   rr_ptr resets 0. Undefined: fixed lowest-index priority, no rr_ptr flop.
// TESTING
//  1 reset: rst=1 with irq_src=8'hFF -> all outputs 0; after release PENDING=8'h00
//    until ENABLE irrelevant, EDGE=0 so PENDING tracks s within SYNC_STAGES cycles.
//  2 EDGE=8'h01,ENABLE=8'h01, pulse src0 1 cycle -> PENDING=1, irq_external=1;
//    CLAIM read=1, irq_external=0; COMPLETE 1 -> in_service cleared, no re-fire.
//  3 src2,src5 pending edge, ENABLE=8'h24 -> CLAIM=3; COMPLETE 3; CLAIM=6
//    (RR_EN: after claim 3 and complete, claim=6; next src2 edge then claim=3).
//  4 level src4 held high, ENABLE=8'h10 -> CLAIM=5, COMPLETE 5 -> irq_external
//    re-asserts; drop src4 -> PENDING=0 after SYNC_STAGES cycles.
//  5 COMPLETE 2 while svc_id=5 -> ignored, irq stays low; CLAIM while busy -> 0.
//  6 two irq_ack pulses -> ACKCNT=2; write 0x14 -> ACKCNT=0; each access
//    bus_ready exactly 1 cycle after bus_valid.

Source files
------------

// File: rtl/qar_irq_ctrl.sv
// qar_irq_ctrl -- external interrupt controller for qar_core.
//
// Synchronises NUM_SRC asynchronous sources, tracks pending state (edge sources
// are latched, level sources follow the synchronised input), masks with ENABLE,
// selects one winner and drives a registered irq_external. Software claims and
// completes interrupts through a small MMIO register file on a valid/ready bus.
// Rising edges of irq_ack are counted in a free-running debug counter.
//
// Register map (byte offset, bits [4:2] select, [1:0] ignored):
//   0x00 PENDING  R, W1C (edge sources only)
//   0x04 ENABLE   R/W
//   0x08 EDGE     R/W (1 = rising-edge source, 0 = level source)
//   0x0C CLAIM    R   (winner id = index+1, 0 if none or already in service)
//   0x10 COMPLETE W   (wdata[4:0] must equal the claimed id)
//   0x14 ACKCNT   R, any write clears
//
// Optional feature macro: QAR_IRQ_ROUND_ROBIN_EN
//   defined   -> winner is the first active source at or after rr_ptr
//   undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   irq_src      raw asynchronous interrupt sources, active-high
//   bus_valid    MMIO request, held until bus_ready
//   bus_we       1 = write, 0 = read
//   bus_addr     byte offset into the register map
//   bus_wdata    write data
//   bus_ready    one-cycle response strobe
//   bus_rdata    read data, valid while bus_ready is high
//   irq_external interrupt request to the core
//   irq_ack      interrupt acknowledge from the core
module qar_irq_ctrl #(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               bus_valid,
    input  logic               bus_we,
    input  logic [4:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    output logic               bus_ready,
    output logic [31:0]        bus_rdata,
    output logic               irq_external,
    input  logic               irq_ack
);

    typedef logic [NUM_SRC-1:0] vec_t;
    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [2:0] REG_PENDING  = 3'd0;
    localparam logic [2:0] REG_ENABLE   = 3'd1;
    localparam logic [2:0] REG_EDGE     = 3'd2;
    localparam logic [2:0] REG_CLAIM    = 3'd3;
    localparam logic [2:0] REG_COMPLETE = 3'd4;
    localparam logic [2:0] REG_ACKCNT   = 3'd5;

    vec_t        sync_q [SYNC_STAGES];
    vec_t        s, s_prev;
    vec_t        enable_r, edge_mode, edge_pend;
    vec_t        pending, active, clr, edge_next;
    logic        in_service;
    logic [4:0]  svc_id;
    logic [31:0] ack_cnt;
    logic        ack_prev;
    logic        irq_q;
    logic [31:0] rdata_q, rd_val;
    state_t      state, state_next;
    logic        win_found;
    logic [4:0]  win_idx, claim_id;
    logic        capture, wr, rd;
    logic [2:0]  sel;

    // Address LSBs and write bits above NUM_SRC have no function.
    logic unused;
    assign unused = ^{bus_addr[1:0], bus_wdata[31:NUM_SRC]};

    // ---------------- synchroniser and edge-detect history ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every synchroniser stage is reset so no stale level can be
            // mistaken for a rising edge right after reset.
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            s_prev <= '0;
        end else begin
            // NOTE: non-blocking assignments let each stage take the previous
            // stage's old value, forming a true shift chain.
            sync_q[0] <= irq_src;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            s_prev <= s;
        end
    end

    assign s       = sync_q[SYNC_STAGES-1];
    assign pending = (edge_pend & edge_mode) | (s & ~edge_mode);
    assign active  = pending & enable_r;

    // ---------------- bus decode ----------------
    assign sel     = bus_addr[4:2];
    assign capture = (state == IDLE) && bus_valid;
    assign wr      = capture && bus_we;
    assign rd      = capture && !bus_we;

`ifdef QAR_IRQ_ROUND_ROBIN_EN
    logic [4:0] rr_ptr;

    always_comb begin
        int idx;
        // NOTE: defaults first so every path assigns every output; no latches.
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!win_found && active[idx]) begin
                win_found = 1'b1;
                win_idx   = 5'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (rd && sel == REG_CLAIM && win_found && !in_service)
            rr_ptr <= (win_idx == 5'(NUM_SRC - 1)) ? 5'd0 : win_idx + 5'd1;
    end
`else
    // Scan downwards so the lowest active index is the one left standing.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_found = 1'b1;
                win_idx   = 5'(i);
            end
        end
    end
`endif

    // Claim succeeds only when nothing is already in service.
    assign claim_id = (win_found && !in_service) ? win_idx + 5'd1 : 5'd0;

    // Latched edge bits are cleared by W1C or by a successful claim; a new
    // edge in the same cycle wins. Switching a source to level mode drops
    // its latch so a stale edge cannot reappear later.
    always_comb begin
        clr = '0;
        if (wr && sel == REG_PENDING) clr = clr | bus_wdata[NUM_SRC-1:0];
        if (rd && sel == REG_CLAIM && claim_id != 5'd0) clr = clr | (vec_t'(1) << win_idx);
        edge_next = (wr && sel == REG_EDGE) ? bus_wdata[NUM_SRC-1:0] : edge_mode;
    end

    // ---------------- register file and side effects ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_r   <= '0;
            edge_mode  <= '0;
            edge_pend  <= '0;
            in_service <= 1'b0;
            svc_id     <= '0;
            ack_cnt    <= '0;
            ack_prev   <= 1'b0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            edge_pend <= ((edge_pend & ~clr) | (s & ~s_prev & edge_mode)) & edge_next;
            edge_mode <= edge_next;
            if (wr && sel == REG_ENABLE) enable_r <= bus_wdata[NUM_SRC-1:0];

            if (rd && sel == REG_CLAIM && claim_id != 5'd0) begin
                in_service <= 1'b1;
                svc_id     <= claim_id;
            end else if (wr && sel == REG_COMPLETE && bus_wdata[4:0] == svc_id) begin
                in_service <= 1'b0;
            end

            ack_prev <= irq_ack;
            if (wr && sel == REG_ACKCNT)
                ack_cnt <= '0;
            else if (irq_ack && !ack_prev)
                ack_cnt <= ack_cnt + 32'd1;

            irq_q <= (|active) && !in_service;

            if (capture) rdata_q <= bus_we ? 32'd0 : rd_val;
        end
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            REG_PENDING: rd_val = 32'(pending);
            REG_ENABLE:  rd_val = 32'(enable_r);
            REG_EDGE:    rd_val = 32'(edge_mode);
            REG_CLAIM:   rd_val = {27'd0, claim_id};
            REG_ACKCNT:  rd_val = ack_cnt;
            default:     rd_val = '0;
        endcase
    end

    // ---------------- bus FSM: state register / next state / outputs ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus_valid) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus_ready = (state == RESP);
    end

    assign bus_rdata    = rdata_q;
    assign irq_external = irq_q;

endmodule

// File: tb/tb_qar_irq_ctrl.sv
// Testbench for qar_irq_ctrl: directed scenarios followed by randomized
// register/source traffic. Bus responses are checked by a scoreboard monitor
// against a behavioural model of the controller kept in this file.
module tb_qar_irq_ctrl;

    localparam int N    = 8;
    localparam int SYNC = 2;
    localparam int SETTLE = SYNC + 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq_src;
    logic         bus_valid, bus_we;
    logic [4:0]   bus_addr;
    logic [31:0]  bus_wdata;
    logic         bus_ready;
    logic [31:0]  bus_rdata;
    logic         irq_external;
    logic         irq_ack;

    qar_irq_ctrl #(.NUM_SRC(N), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .irq_external(irq_external), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_src, m_enable, m_edge, m_epend;
    logic         m_in_svc;
    int           m_svc_id;
    logic [31:0]  m_ackcnt;
    int           m_rr;

    task automatic m_reset();
        m_enable = '0; m_edge = '0; m_epend = '0;
        m_in_svc = 1'b0; m_svc_id = 0; m_ackcnt = '0; m_rr = 0;
    endtask

    function automatic logic [N-1:0] m_pending();
        return (m_epend & m_edge) | (m_src & ~m_edge);
    endfunction

    function automatic int m_winner();
        logic [N-1:0] a;
        a = m_pending() & m_enable;
`ifdef QAR_IRQ_ROUND_ROBIN_EN
        for (int k = 0; k < N; k++) if (a[(m_rr + k) % N]) return (m_rr + k) % N;
`else
        for (int i = 0; i < N; i++) if (a[i]) return i;
`endif
        return -1;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        logic        chk;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (!rst && bus_ready) begin
            if (sb.size() == 0) begin
                check("spurious_ready", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.chk) check(mon_e.name, bus_rdata, mon_e.exp);
            end
        end
    end

    // ---------------- bus and stimulus helpers ----------------
    task automatic bus_op(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                          input logic chk, input logic [31:0] exp, input string name);
        int n;
        sb.push_back('{name, chk, exp});
        @(negedge clk);
        bus_valid = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_ready && n < 4);
        check({name, "_latency"}, 32'(n), 32'd1);
        bus_valid = 1'b0; bus_we = 1'b0; bus_wdata = $urandom;
        @(negedge clk);
        check({name, "_ready_drop"}, 32'(bus_ready), 32'd0);
    endtask

    task automatic check_irq(input string name);
        repeat (2) @(negedge clk);
        check(name, 32'(irq_external), 32'(((m_pending() & m_enable) != '0) && !m_in_svc));
    endtask

    task automatic set_src(input logic [N-1:0] v);
        @(negedge clk);
        m_epend = m_epend | (v & ~m_src & m_edge);
        m_src = v; irq_src = v;
        repeat (SETTLE) @(negedge clk);
        check_irq("irq_after_src");
    endtask

    task automatic pulse_src(input logic [N-1:0] mask);
        logic [N-1:0] m;
        m = mask & ~m_src;
        @(negedge clk);
        irq_src = m_src | m;
        @(negedge clk);
        irq_src = m_src;
        m_epend = m_epend | (m & m_edge);
        repeat (SETTLE) @(negedge clk);
        check_irq("irq_after_pulse");
    endtask

    task automatic w_enable(input logic [31:0] v);
        bus_op(1'b1, 5'h04, v, 1'b0, 32'd0, "wr_enable");
        m_enable = v[N-1:0];
        check_irq("irq_after_enable");
    endtask

    task automatic w_edge(input logic [31:0] v);
        bus_op(1'b1, 5'h08, v, 1'b0, 32'd0, "wr_edge");
        m_edge = v[N-1:0];
        m_epend = m_epend & m_edge;
        check_irq("irq_after_edge");
    endtask

    task automatic w1c(input logic [31:0] v);
        bus_op(1'b1, 5'h00 | 5'($urandom_range(0, 3)), v, 1'b0, 32'd0, "w1c_pending");
        m_epend = m_epend & ~v[N-1:0];
        check_irq("irq_after_w1c");
    endtask

    task automatic r_reg(input logic [4:0] addr, input string name);
        logic [31:0] e;
        case (addr[4:2])
            3'd0:    e = 32'(m_pending());
            3'd1:    e = 32'(m_enable);
            3'd2:    e = 32'(m_edge);
            3'd5:    e = m_ackcnt;
            default: e = 32'd0;
        endcase
        bus_op(1'b0, addr, 32'd0, 1'b1, e, name);
    endtask

    // want >= 0 overrides the model's answer with a literal expectation.
    task automatic do_claim(input int want);
        int w;
        int e;
        w = m_winner();
        e = (!m_in_svc && w >= 0) ? w + 1 : 0;
        bus_op(1'b0, 5'h0C, 32'd0, 1'b1, 32'((want >= 0) ? want : e), "claim");
        if (e != 0) begin
            m_in_svc = 1'b1; m_svc_id = e;
            m_epend[w] = 1'b0;
            m_rr = (w + 1) % N;
        end
        check_irq("irq_after_claim");
    endtask

    task automatic do_complete(input int id);
        bus_op(1'b1, 5'h10, {$urandom_range(0, 32'h7FF_FFFF), 5'(id)}, 1'b0, 32'd0, "complete");
        if (id == m_svc_id) m_in_svc = 1'b0;
        check_irq("irq_after_complete");
    endtask

    task automatic ack_pulse();
        @(negedge clk); irq_ack = 1'b1;
        @(negedge clk); irq_ack = 1'b0;
        m_ackcnt = m_ackcnt + 32'd1;
    endtask

    task automatic clr_ackcnt();
        bus_op(1'b1, 5'h14, $urandom, 1'b0, 32'd0, "clr_ackcnt");
        m_ackcnt = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; irq_src = '1; bus_valid = 1'b0; bus_we = 1'b0;
        bus_addr = '0; bus_wdata = '0; irq_ack = 1'b0;
        m_reset(); m_src = '1;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus_ready), 32'd0);
        check("rst_rdata", bus_rdata, 32'd0);
        check("rst_irq", 32'(irq_external), 32'd0);
        rst = 1'b0;
        repeat (SETTLE) @(negedge clk);
        r_reg(5'h00, "level_pending_ff");
        check_irq("irq_disabled");
        set_src('0);
        r_reg(5'h00, "pending_zero");

        // single edge source: pulse, claim, complete, no re-fire
        w_edge(32'h01); w_enable(32'h01);
        pulse_src(8'h01);
        r_reg(5'h00, "pending_src0");
        do_claim(1);
        do_complete(1);
        r_reg(5'h00, "pending_after_claim");

        // two edge sources, priority order
        w_edge(32'hFF); w_enable(32'h24);
        pulse_src(8'h24);
        do_claim(3); do_complete(3);
        do_claim(6); do_complete(6);
        pulse_src(8'h04);
        do_claim(3); do_complete(3);

        // level source, busy behaviour, mismatched complete
        w_edge(32'hEF); w_enable(32'h10);
        set_src(8'h10);
        do_claim(5);
        do_complete(2);
        do_claim(0);
        do_complete(5);
        set_src(8'h00);
        r_reg(5'h00, "level_dropped");

        // ack counter
        ack_pulse(); ack_pulse();
        r_reg(5'h14, "ackcnt_two");
        clr_ackcnt();
        r_reg(5'h14, "ackcnt_cleared");
        r_reg(5'h18, "unmapped_read");
        w_enable(32'hFFFF_FF00);
        r_reg(5'h04, "enable_high_bits");

        // randomized traffic
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0: set_src(N'($urandom));
                1: pulse_src(N'(1) << $urandom_range(0, N - 1));
                2: w_enable($urandom);
                3: w_edge($urandom);
                4: r_reg(5'h00, "rand_pending");
                5: do_claim(-1);
                6: do_complete(($urandom_range(0, 1) == 1) ? m_svc_id : int'($urandom_range(0, 31)));
                7: w1c($urandom);
                8: begin ack_pulse(); r_reg(5'h14, "rand_ackcnt"); end
                default: case ($urandom_range(0, 3))
                    0: r_reg(5'h04, "rand_enable");
                    1: r_reg(5'h08, "rand_edge");
                    2: r_reg(5'h1C, "rand_unmapped");
                    default: clr_ackcnt();
                endcase
            endcase
        end

        // reset in the middle of a transaction drops the response
        @(negedge clk);
        bus_valid = 1'b1; bus_we = 1'b0; bus_addr = 5'h04;
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check("midrst_ready", 32'(bus_ready), 32'd0);
        check("midrst_rdata", bus_rdata, 32'd0);
        check("midrst_irq", 32'(irq_external), 32'd0);
        @(negedge clk);
        bus_valid = 1'b0;
        rst = 1'b0;
        m_reset();
        repeat (SETTLE) @(negedge clk);
        r_reg(5'h04, "enable_after_rst");
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
